// File: rtl/cmd_arbiter.sv
// Round-robin arbiter that shares one CMD_master between N_REQ command requesters.
// Latches one winner's index/arg, runs the command, and reports status back to that requester.
module cmd_arbiter #(
    parameter int N_REQ    = 2,
    parameter int WATCHDOG = 1024,
    parameter int WD_W     = 16
) (
    input  logic                  CLK_host,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [6*N_REQ-1:0]    req_index,
    input  logic [32*N_REQ-1:0]   req_arg,
    output logic [N_REQ-1:0]      req_grant,
    output logic [N_REQ-1:0]      req_done,
    output logic                  req_error,
    output logic                  wd_error,
    output logic [31:0]           resp_status,
    output logic                  arb_busy,
    output logic                  new_cmd,
    output logic [5:0]            cmd_index,
    output logic [31:0]           cmd_arg,
    input  logic                  cmd_busy,
    input  logic                  cmd_complete,
    input  logic                  timeout_error,
    input  logic [31:0]           response_status
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_LIM = (WATCHDOG > 0) ? WATCHDOG - 1 : 0;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIM);
    localparam logic [WD_W-1:0] WD_MAX  = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, REPORT} state_t;

    state_t             state, state_d;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
    logic [WD_W-1:0]    wd_cnt, wd_cnt_d;
    logic [N_REQ-1:0]   grant_d, done_d;
    logic               error_d, wd_error_d, new_cmd_d;
    logic [31:0]        status_d, arg_d;
    logic [5:0]         index_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx, cand;
    logic [N_REQ-1:0]   win_onehot;
    logic [5:0]         win_index;
    logic [31:0]        win_arg;

    // Search upward from the requester after the last winner, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        cand      = rr_ptr;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = PTR_W'((int'(rr_ptr) + off) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_index  = '0;
        win_arg    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_onehot[i] = 1'b1;
                win_index     = req_index[6*i +: 6];
                win_arg       = req_arg[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        wd_cnt_d   = wd_cnt;
        grant_d    = req_grant;
        done_d     = '0;
        error_d    = req_error;
        wd_error_d = wd_error;
        status_d   = resp_status;
        new_cmd_d  = 1'b0;
        index_d    = cmd_index;
        arg_d      = cmd_arg;

        case (state)
            IDLE: begin
                if (!cmd_busy && win_found) begin
                    state_d   = ISSUE;
                    grant_d   = win_onehot;
                    rr_ptr_d  = win_idx;
                    index_d   = win_index;
                    arg_d     = win_arg;
                    new_cmd_d = 1'b1;
                end
            end
            ISSUE: begin
                wd_cnt_d = '0;
                state_d  = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A master timeout takes priority over a completion in the same cycle.
                if (timeout_error) begin
                    status_d   = '0;
                    error_d    = 1'b1;
                    wd_error_d = 1'b0;
                    done_d     = req_grant;
                    state_d    = REPORT;
                end else if (cmd_complete) begin
                    status_d   = response_status;
                    error_d    = 1'b0;
                    wd_error_d = 1'b0;
                    done_d     = req_grant;
                    state_d    = REPORT;
                end else if (WATCHDOG != 0 && wd_cnt == WD_LAST) begin
                    status_d   = '0;
                    error_d    = 1'b1;
                    wd_error_d = 1'b1;
                    done_d     = req_grant;
                    state_d    = REPORT;
                end else if (wd_cnt != WD_MAX) begin
                    wd_cnt_d = wd_cnt + WD_W'(1);
                end
            end
            REPORT: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_host) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= PTR_W'(N_REQ - 1);
            wd_cnt      <= '0;
            req_grant   <= '0;
            req_done    <= '0;
            req_error   <= 1'b0;
            wd_error    <= 1'b0;
            resp_status <= '0;
            arb_busy    <= 1'b0;
            new_cmd     <= 1'b0;
            cmd_index   <= '0;
            cmd_arg     <= '0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            wd_cnt      <= wd_cnt_d;
            req_grant   <= grant_d;
            req_done    <= done_d;
            req_error   <= error_d;
            wd_error    <= wd_error_d;
            resp_status <= status_d;
            arb_busy    <= (state_d != IDLE);
            new_cmd     <= new_cmd_d;
            cmd_index   <= index_d;
            cmd_arg     <= arg_d;
        end
    end

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: one instance with a 16-cycle watchdog, one with it disabled.
module tb_cmd_arbiter;

    localparam int N = 2;

    logic              CLK_host = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [6*N-1:0]    req_index;
    logic [32*N-1:0]   req_arg;
    logic              cmd_busy, cmd_complete, timeout_error;
    logic [31:0]       response_status;

    logic [N-1:0]      req_grant, req_done;
    logic              req_error, wd_error, arb_busy, new_cmd;
    logic [31:0]       resp_status, cmd_arg;
    logic [5:0]        cmd_index;

    logic [N-1:0]      req_grant_z, req_done_z;
    logic              req_error_z, wd_error_z, arb_busy_z, new_cmd_z;
    logic [31:0]       resp_status_z, cmd_arg_z;
    logic [5:0]        cmd_index_z;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CLK_host = ~CLK_host;

    cmd_arbiter #(.N_REQ(N), .WATCHDOG(16), .WD_W(16)) dut (
        .CLK_host(CLK_host), .reset(reset),
        .req_valid(req_valid), .req_index(req_index), .req_arg(req_arg),
        .req_grant(req_grant), .req_done(req_done), .req_error(req_error),
        .wd_error(wd_error), .resp_status(resp_status), .arb_busy(arb_busy),
        .new_cmd(new_cmd), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
        .cmd_busy(cmd_busy), .cmd_complete(cmd_complete),
        .timeout_error(timeout_error), .response_status(response_status)
    );

    cmd_arbiter #(.N_REQ(N), .WATCHDOG(0), .WD_W(16)) dut_z (
        .CLK_host(CLK_host), .reset(reset),
        .req_valid(req_valid), .req_index(req_index), .req_arg(req_arg),
        .req_grant(req_grant_z), .req_done(req_done_z), .req_error(req_error_z),
        .wd_error(wd_error_z), .resp_status(resp_status_z), .arb_busy(arb_busy_z),
        .new_cmd(new_cmd_z), .cmd_index(cmd_index_z), .cmd_arg(cmd_arg_z),
        .cmd_busy(cmd_busy), .cmd_complete(cmd_complete),
        .timeout_error(timeout_error), .response_status(response_status)
    );

    task automatic tick();
        @(posedge CLK_host);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [1:0] order [3];
        logic       seen_done, seen_new, held;

        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;

        reset = 1'b1; req_valid = '0; req_index = '0; req_arg = '0;
        cmd_busy = 1'b0; cmd_complete = 1'b0; timeout_error = 1'b0;
        response_status = '0;
        tick(); tick();
        chk("rst_grant",  32'(req_grant),  32'h0);
        chk("rst_done",   32'(req_done),   32'h0);
        chk("rst_newcmd", 32'(new_cmd),    32'h0);
        chk("rst_busy",   32'(arb_busy),   32'h0);
        chk("rst_index",  32'(cmd_index),  32'h0);
        chk("rst_arg",    cmd_arg,         32'h0);
        chk("rst_status", resp_status,     32'h0);
        chk("rst_err",    32'({req_error, wd_error}), 32'h0);
        reset = 1'b0;

        // Single request from requester 0
        req_valid = 2'b01; req_index[5:0] = 6'h11; req_arg[31:0] = 32'hAAAA_AAAA;
        response_status = 32'h0000_0900;
        tick();
        chk("s_newcmd", 32'(new_cmd),   32'h1);
        chk("s_grant",  32'(req_grant), 32'h1);
        chk("s_index",  32'(cmd_index), 32'h11);
        chk("s_arg",    cmd_arg,        32'hAAAA_AAAA);
        chk("s_busy",   32'(arb_busy),  32'h1);
        req_valid = 2'b00; req_index[5:0] = 6'h3F; req_arg[31:0] = 32'h1234_5678;
        tick();
        chk("s_newcmd_lo", 32'(new_cmd), 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (req_done != 2'b00) seen_done = 1'b1;
        end
        chk("s_no_early_done", 32'(seen_done), 32'h0);
        chk("s_index_held", 32'(cmd_index), 32'h11);
        chk("s_arg_held",   cmd_arg,        32'hAAAA_AAAA);
        cmd_complete = 1'b1;
        tick();
        chk("s_done",   32'(req_done),  32'h1);
        chk("s_status", resp_status,    32'h0000_0900);
        chk("s_err",    32'(req_error), 32'h0);
        chk("s_wderr",  32'(wd_error),  32'h0);
        cmd_complete = 1'b0;
        tick();
        chk("s_done_lo",     32'(req_done),  32'h0);
        chk("s_grant_lo",    32'(req_grant), 32'h0);
        chk("s_idle",        32'(arb_busy),  32'h0);
        chk("s_status_hold", resp_status,    32'h0000_0900);

        // Reset clears status and returns the pointer to favour requester 0
        reset = 1'b1;
        tick();
        chk("rst2_status", resp_status, 32'h0);
        reset = 1'b0;

        // Contention: both requesters held valid for three transactions
        req_valid = 2'b11;
        req_index[5:0]  = 6'h0C; req_arg[31:0]  = 32'h1000_0000;
        req_index[11:6] = 6'h0D; req_arg[63:32] = 32'h2000_0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("c_grant",  32'(req_grant), 32'(order[k]));
            chk("c_index",  32'(cmd_index), (order[k] == 2'b10) ? 32'h0D : 32'h0C);
            chk("c_arg",    cmd_arg, (order[k] == 2'b10) ? 32'h2000_0001 : 32'h1000_0000);
            tick();
            cmd_complete = 1'b1; response_status = 32'h100 + 32'(k);
            tick();
            chk("c_done",   32'(req_done), 32'(order[k]));
            chk("c_status", resp_status,   32'h100 + 32'(k));
            cmd_complete = 1'b0;
            if (k == 2) req_valid = 2'b00;
            tick();
            chk("c_done_lo", 32'(req_done), 32'h0);
        end

        // Master timeout coincident with completion
        req_valid = 2'b01;
        tick();
        chk("t_grant", 32'(req_grant), 32'h1);
        req_valid = 2'b00;
        tick();
        cmd_complete = 1'b1; timeout_error = 1'b1; response_status = 32'hDEAD_BEEF;
        tick();
        chk("t_done",   32'(req_done),  32'h1);
        chk("t_err",    32'(req_error), 32'h1);
        chk("t_wderr",  32'(wd_error),  32'h0);
        chk("t_status", resp_status,    32'h0);
        cmd_complete = 1'b0; timeout_error = 1'b0;
        tick();

        // Busy gating: no grant while the master reports busy
        cmd_busy = 1'b1; req_valid = 2'b10;
        seen_new = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (new_cmd || arb_busy) seen_new = 1'b1;
        end
        chk("b_gated", 32'(seen_new), 32'h0);
        cmd_busy = 1'b0;
        tick();
        chk("b_newcmd", 32'(new_cmd),   32'h1);
        chk("b_grant",  32'(req_grant), 32'h2);
        req_valid = 2'b00;
        tick();
        cmd_complete = 1'b1; response_status = 32'h0000_0ABC;
        tick();
        chk("b_done",   32'(req_done), 32'h2);
        chk("b_status", resp_status,   32'h0000_0ABC);
        cmd_complete = 1'b0;
        tick();

        // Watchdog expiry with WATCHDOG=16; the disabled instance keeps waiting
        req_valid = 2'b10; response_status = 32'h5555_5555;
        tick();
        chk("w_grant", 32'(req_grant), 32'h2);
        req_valid = 2'b00;
        tick();
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (req_done != 2'b00) seen_done = 1'b1;
        end
        chk("w_no_early", 32'(seen_done), 32'h0);
        tick();
        chk("w_done",   32'(req_done),  32'h2);
        chk("w_err",    32'(req_error), 32'h1);
        chk("w_wderr",  32'(wd_error),  32'h1);
        chk("w_status", resp_status,    32'h0);
        chk("w_z_done", 32'(req_done_z), 32'h0);
        tick();
        chk("w_idle",     32'(arb_busy),   32'h0);
        chk("w_z_busy",   32'(arb_busy_z), 32'h1);

        // Disabled watchdog: still waiting after 2000 cycles
        seen_done = 1'b0; seen_new = 1'b0; held = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (req_done_z != 2'b00) seen_done = 1'b1;
            if (new_cmd_z) seen_new = 1'b1;
            if (req_grant_z != 2'b10 || cmd_index_z != 6'h0D ||
                cmd_arg_z != 32'h2000_0001 || !arb_busy_z) held = 1'b0;
        end
        chk("z_no_done",  32'(seen_done), 32'h0);
        chk("z_no_new",   32'(seen_new),  32'h0);
        chk("z_held",     32'(held),      32'h1);
        cmd_complete = 1'b1; response_status = 32'h0000_0777;
        tick();
        chk("z_done",     32'(req_done_z),   32'h2);
        chk("z_err",      32'({req_error_z, wd_error_z}), 32'h0);
        chk("z_status",   resp_status_z,     32'h0000_0777);
        chk("z_dut_idle", 32'(req_done),     32'h0);
        chk("z_dut_hold", resp_status,       32'h0);
        cmd_complete = 1'b0;
        tick();

        // Reset during WAIT_DONE, then requester 0 must win
        req_valid = 2'b10;
        tick();
        chk("r_grant1", 32'(req_grant), 32'h2);
        tick(); tick();
        reset = 1'b1; req_valid = 2'b11;
        tick();
        chk("r_grant",  32'(req_grant), 32'h0);
        chk("r_busy",   32'(arb_busy),  32'h0);
        chk("r_index",  32'(cmd_index), 32'h0);
        chk("r_arg",    cmd_arg,        32'h0);
        chk("r_done",   32'(req_done),  32'h0);
        chk("r_err",    32'({req_error, wd_error}), 32'h0);
        reset = 1'b0;
        tick();
        chk("r_newcmd", 32'(new_cmd),   32'h1);
        chk("r_win0",   32'(req_grant), 32'h1);
        chk("r_win0ix", 32'(cmd_index), 32'h0C);
        req_valid = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
